// File: rtl/chn_in_router.sv
// Input-channel router: decodes a {addr,len} header and forwards the packet one-hot to one of NUM_FIFOS.
// Define CHN_PARITY_CHK_EN to expect and check a trailing XOR parity byte on every packet.
module chn_in_router #(
  parameter int DATA_SIZE       = 8,
  parameter int PKT_LENGTH_BITS = 5,
  parameter int NUM_FIFOS       = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic [DATA_SIZE-1:0] i_data_in,
  input  logic                 i_chn_en,
  input  logic                 i_clr_errors,
  input  logic [NUM_FIFOS-1:0] i_fifo_full,
  output logic [DATA_SIZE-1:0] o_data_out,
  output logic [NUM_FIFOS-1:0] o_pkt_to_fifo_en,
  output logic                 o_busy,
  output logic                 o_error
);

  localparam int PKT_ADDR_BITS = DATA_SIZE - PKT_LENGTH_BITS;
  localparam int ADDR_SPACE    = 1 << PKT_ADDR_BITS;
  localparam int CNT_W         = PKT_LENGTH_BITS + 1;
  localparam logic [PKT_ADDR_BITS:0] FIFO_LIMIT = (PKT_ADDR_BITS+1)'(NUM_FIFOS);

  generate
    if (NUM_FIFOS < 1 || NUM_FIFOS > ADDR_SPACE) begin : g_bad_num_fifos
      $error("chn_in_router: NUM_FIFOS must be in 1..2**PKT_ADDR_BITS");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_FWD,
    S_DROP
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [PKT_ADDR_BITS-1:0]   r_addr;
  logic [PKT_ADDR_BITS-1:0]   w_addr_nxt;
  logic [CNT_W-1:0]           r_cnt;
  logic [CNT_W-1:0]           w_cnt_nxt;
  logic [DATA_SIZE-1:0]       r_data_out;
  logic [DATA_SIZE-1:0]       w_data_nxt;
  logic [NUM_FIFOS-1:0]       r_en;
  logic [NUM_FIFOS-1:0]       w_en_nxt;
  logic                       r_last;
  logic                       w_last_nxt;
  logic                       r_error;
  logic                       w_err_set;
  logic                       w_busy;

  logic [PKT_ADDR_BITS-1:0]   w_hdr_addr;
  logic [PKT_LENGTH_BITS-1:0] w_hdr_len;
  logic                       w_hdr_ok;
  logic [CNT_W-1:0]           w_cnt_load;
  logic [ADDR_SPACE-1:0]      w_full_ext;

`ifdef CHN_PARITY_CHK_EN
  logic [DATA_SIZE-1:0]       r_par;
  logic [DATA_SIZE-1:0]       w_par_nxt;
`endif

  function automatic logic [NUM_FIFOS-1:0] f_onehot(input logic [PKT_ADDR_BITS-1:0] a);
    logic [NUM_FIFOS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      if (a == PKT_ADDR_BITS'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  assign w_hdr_addr = i_data_in[DATA_SIZE-1:PKT_LENGTH_BITS];
  assign w_hdr_len  = i_data_in[PKT_LENGTH_BITS-1:0];
  assign w_hdr_ok   = ({1'b0, w_hdr_addr} < FIFO_LIMIT) && (w_hdr_len != '0);

  // The remaining count covers payload bytes plus the parity byte when it is present.
`ifdef CHN_PARITY_CHK_EN
  assign w_cnt_load = {1'b0, w_hdr_len} + CNT_W'(1);
`else
  assign w_cnt_load = {1'b0, w_hdr_len};
`endif

  // Widened full vector so any decodable address can index it safely.
  always_comb begin
    w_full_ext                = '0;
    w_full_ext[NUM_FIFOS-1:0] = i_fifo_full;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data_out;
    w_en_nxt    = '0;
    w_last_nxt  = 1'b0;
    w_err_set   = 1'b0;
    w_busy      = 1'b0;
`ifdef CHN_PARITY_CHK_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      S_IDLE: begin
        if (i_chn_en) begin
          // r_last means chn_en never dropped after the final byte: a long packet.
          if (r_last) begin
            w_err_set   = 1'b1;
            w_state_nxt = S_DROP;
          end else if (!w_hdr_ok) begin
            w_err_set   = 1'b1;
            w_state_nxt = S_DROP;
          end else if (w_full_ext[w_hdr_addr]) begin
            w_busy = 1'b1;
          end else begin
            w_addr_nxt  = w_hdr_addr;
            w_cnt_nxt   = w_cnt_load;
            w_data_nxt  = i_data_in;
            w_en_nxt    = f_onehot(w_hdr_addr);
            w_state_nxt = S_FWD;
`ifdef CHN_PARITY_CHK_EN
            w_par_nxt   = i_data_in;
`endif
          end
        end
      end
      S_FWD: begin
        if (!i_chn_en) begin
          w_err_set   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_full_ext[r_addr]) begin
          w_busy = 1'b1;
        end else begin
          w_data_nxt = i_data_in;
          w_en_nxt   = f_onehot(r_addr);
          w_cnt_nxt  = r_cnt - CNT_W'(1);
`ifdef CHN_PARITY_CHK_EN
          w_par_nxt  = r_par ^ i_data_in;
`endif
          if (r_cnt == CNT_W'(1)) begin
            w_state_nxt = S_IDLE;
            w_last_nxt  = 1'b1;
`ifdef CHN_PARITY_CHK_EN
            if (i_data_in != r_par) w_err_set = 1'b1;
`endif
          end
        end
      end
      S_DROP: begin
        if (!i_chn_en) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_data_out <= '0;
      r_en       <= '0;
      r_last     <= 1'b0;
      r_error    <= 1'b0;
`ifdef CHN_PARITY_CHK_EN
      r_par      <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_data_out <= w_data_nxt;
      r_en       <= w_en_nxt;
      r_last     <= w_last_nxt;
`ifdef CHN_PARITY_CHK_EN
      r_par      <= w_par_nxt;
`endif
      if (w_err_set) begin
        r_error <= 1'b1;
      end else if (i_clr_errors) begin
        r_error <= 1'b0;
      end
    end
  end

  assign o_data_out       = r_data_out;
  assign o_pkt_to_fifo_en = r_en;
  assign o_busy           = w_busy & i_rstn;
  assign o_error          = r_error;

endmodule

// File: tb/tb_chn_in_router.sv
// Randomized bench for chn_in_router (NUM_FIFOS=3) against a packet-level reference model.
module tb_chn_in_router;

  localparam int DW = 8;
  localparam int LB = 5;
  localparam int AB = DW - LB;
  localparam int NF = 3;
`ifdef CHN_PARITY_CHK_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic          chnEn;
  logic          clrErrors;
  logic [DW-1:0] dataIn;
  logic [NF-1:0] fifoFull;
  logic [DW-1:0] dataOut;
  logic [NF-1:0] pktEn;
  logic          busy;
  logic          error;

  int            checks = 0;
  int            passed = 0;
  logic [DW-1:0] expData;
  logic          expErr;
  bit            allowClr;
  logic [DW-1:0] pkt[$];

  chn_in_router #(
    .DATA_SIZE       (DW),
    .PKT_LENGTH_BITS (LB),
    .NUM_FIFOS       (NF)
  ) dut (
    .i_clk            (clk),
    .i_rstn           (rstn),
    .i_data_in        (dataIn),
    .i_chn_en         (chnEn),
    .i_clr_errors     (clrErrors),
    .i_fifo_full      (fifoFull),
    .o_data_out       (dataOut),
    .o_pkt_to_fifo_en (pktEn),
    .o_busy           (busy),
    .o_error          (error)
  );

  always #5 clk = ~clk;

  function automatic logic [NF-1:0] onehot(input int a);
    return NF'(1) << a;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // One clock: drive inputs, check combinational busy, then registered outputs after the edge.
  task automatic stepCycle(input logic en, input logic [DW-1:0] d, input logic [NF-1:0] full,
                           input logic expBusy, input logic fwd, input int addr,
                           input logic errSet, input logic clr);
    chnEn     = en;
    dataIn    = d;
    fifoFull  = full;
    clrErrors = clr;
    #1;
    checkOutput("busy", 32'(busy), 32'(expBusy));
    @(posedge clk);
    if (fwd) expData = d;
    if (errSet) expErr = 1'b1;
    else if (clr) expErr = 1'b0;
    #1;
    checkOutput("enable", 32'(pktEn), 32'(fwd ? onehot(addr) : '0));
    checkOutput("data_out", 32'(dataOut), 32'(expData));
    checkOutput("error", 32'(error), 32'(expErr));
  endtask

  task automatic addParity();
    logic [DW-1:0] x;
    x = '0;
    foreach (pkt[i]) x ^= pkt[i];
    if (PAR == 1) pkt.push_back(x);
  endtask

  // Sends pkt[], holding each byte while the model predicts backpressure, then a chn_en-low gap.
  task automatic applyStimulus(input int stallStart, input int stallLen, input int gap, input bit clrAfter);
    logic [AB-1:0] addr;
    logic [DW-1:0] par;
    logic [DW-1:0] rnd;
    logic [NF-1:0] full;
    int            len, expectN, nRouted, idx, cyc;
    bit            valid, inRange, bsy, errSet, clr;
    addr    = pkt[0][DW-1:LB];
    len     = int'(pkt[0][LB-1:0]);
    valid   = (int'(addr) < NF) && (len != 0);
    expectN = len + 1 + PAR;
    nRouted = !valid ? 0 : ((pkt.size() < expectN) ? pkt.size() : expectN);
    par     = '0;
    for (int i = 0; i <= len && i < pkt.size(); i++) par ^= pkt[i];
    idx = 0;
    cyc = 0;
    while (idx < pkt.size() && cyc < 2000) begin
      if (stallLen < 0) begin
        for (int i = 0; i < NF; i++) full[i] = ($urandom_range(0, 3) == 0);
      end else begin
        full = (cyc >= stallStart && cyc < stallStart + stallLen) ? onehot(int'(addr)) : '0;
      end
      inRange = idx < nRouted;
      bsy     = inRange && (((full >> addr) & NF'(1)) != '0);
      errSet  = 1'b0;
      if (!valid && idx == 0) errSet = 1'b1;
      if (valid && idx == expectN) errSet = 1'b1;
      if (PAR == 1 && valid && idx == expectN - 1 && pkt[idx] != par && !bsy) errSet = 1'b1;
      clr = allowClr && ($urandom_range(0, 7) == 0);
      stepCycle(1'b1, pkt[idx], full, bsy, inRange && !bsy, int'(addr), errSet, clr);
      if (!bsy) idx++;
      cyc++;
    end
    if (idx < pkt.size()) checkOutput("stall_timeout", 32'(idx), 32'(pkt.size()));
    for (int g = 0; g < gap; g++) begin
      for (int i = 0; i < NF; i++) full[i] = ($urandom_range(0, 3) == 0);
      rnd = DW'($urandom);
      clr = (clrAfter && g == gap - 1) || (allowClr && ($urandom_range(0, 7) == 0));
      stepCycle(1'b0, rnd, full, 1'b0, 1'b0, 0, (g == 0) && valid && (pkt.size() < expectN), clr);
    end
  endtask

  task automatic buildRandom();
    int            kind, a, len, n;
    logic [DW-1:0] b, x;
    kind = int'($urandom_range(0, 9));
    a    = (kind == 0) ? int'($urandom_range(NF, (1 << AB) - 1)) : int'($urandom_range(0, NF - 1));
    len  = (kind == 1) ? 0 : ((kind == 2) ? (1 << LB) - 1 : int'($urandom_range(1, 6)));
    pkt.delete();
    b = {AB'(a), LB'(len)};
    pkt.push_back(b);
    x = b;
    if (kind <= 1) n = (len == 0) ? 2 : len;
    else if (kind == 3) n = int'($urandom_range(0, len - 1));
    else n = len;
    for (int i = 0; i < n; i++) begin
      b = DW'($urandom);
      pkt.push_back(b);
      x ^= b;
    end
    if (PAR == 1 && kind >= 2 && kind != 3) begin
      if ($urandom_range(0, 3) == 0) x = x ^ DW'($urandom_range(1, 255));
      pkt.push_back(x);
    end
    if (kind == 4) begin
      n = int'($urandom_range(1, 3));
      for (int i = 0; i < n; i++) pkt.push_back(DW'($urandom));
    end
  endtask

  task automatic resetMidPacket();
    pkt.delete();
    pkt.push_back(8'h06);
    for (int i = 0; i < 6; i++) pkt.push_back(DW'($urandom));
    addParity();
    for (int i = 0; i < 3; i++) stepCycle(1'b1, pkt[i], '0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    chnEn    = 1'b1;
    dataIn   = pkt[3];
    fifoFull = '1;
    #2 rstn = 1'b0;
    #1;
    checkOutput("midrst_enable", 32'(pktEn), 32'd0);
    checkOutput("midrst_error", 32'(error), 32'd0);
    checkOutput("midrst_data", 32'(dataOut), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    expData  = '0;
    expErr   = 1'b0;
    chnEn    = 1'b0;
    fifoFull = '0;
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn      = 1'b0;
    chnEn     = 1'b1;
    dataIn    = 8'h43;
    fifoFull  = '1;
    clrErrors = 1'b0;
    allowClr  = 1'b0;
    expData   = '0;
    expErr    = 1'b0;
    #3;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_enable", 32'(pktEn), 32'd0);
    checkOutput("reset_data", 32'(dataOut), 32'd0);
    checkOutput("reset_error", 32'(error), 32'd0);
    chnEn    = 1'b0;
    fifoFull = '0;
    @(posedge clk);
    #3 rstn = 1'b1;
    @(posedge clk);
    #1;

    pkt.delete(); pkt.push_back(8'h43); pkt.push_back(8'ha1); pkt.push_back(8'hb2); pkt.push_back(8'hc3);
    addParity();
    applyStimulus(0, 0, 2, 1'b0);

    pkt.delete(); pkt.push_back(8'h24); pkt.push_back(8'h11); pkt.push_back(8'h22);
    pkt.push_back(8'h33); pkt.push_back(8'h44);
    addParity();
    applyStimulus(2, 2, 1, 1'b0);

    pkt.delete(); pkt.push_back(8'h61); pkt.push_back(8'h55);
    applyStimulus(0, 0, 2, 1'b1);

    pkt.delete(); pkt.push_back(8'h05); pkt.push_back(8'h01); pkt.push_back(8'h02); pkt.push_back(8'h03);
    applyStimulus(0, 0, 2, 1'b1);

    pkt.delete(); pkt.push_back(8'h22); pkt.push_back(8'h0a); pkt.push_back(8'h0b);
    pkt.push_back(8'h0c); pkt.push_back(8'h0d);
    applyStimulus(0, 0, 2, 1'b1);

`ifdef CHN_PARITY_CHK_EN
    pkt.delete(); pkt.push_back(8'h21); pkt.push_back(8'h05); pkt.push_back(8'h00);
    applyStimulus(0, 0, 2, 1'b1);
`endif

    pkt.delete(); pkt.push_back(8'h61); pkt.push_back(8'h77);
    applyStimulus(0, 0, 1, 1'b0);
    resetMidPacket();

    allowClr = 1'b1;
    repeat (80) begin
      buildRandom();
      applyStimulus(0, -1, int'($urandom_range(1, 3)), 1'b0);
    end

    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
